// File: rtl/score_loader.sv
// score_loader: parses framed UART uploads (HDR, LEN, LEN x {HI, LO}, CSUM)
// into 12-bit note words and writes them to the note RAM.
// Optional inter-byte timeout abort: define SCORE_LOADER_TIMEOUT_EN.
module score_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 104160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  output logic              busy,
  output logic [7:0]        note_count,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {StIdle, StLen, StHi, StLo, StCsum} state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          idx_q, idx_d;
  logic [3:0]          hi_q, hi_d;
  logic [7:0]          csum_q, csum_d;
  logic                busy_d;
  logic                mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [11:0]         mem_wdata_d;
  logic [7:0]          note_count_d;
  logic                load_done_d;
  logic                load_err_d;
  logic                tmo_hit;

`ifdef SCORE_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q;

  // Count idle cycles between bytes while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == StIdle || rx_valid || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 32'd1;
    end
  end

  assign tmo_hit = (state_q != StIdle) && !rx_valid && ((tmo_q + 32'd1) == TIMEOUT_CYC);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      busy       <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      note_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      csum_q     <= csum_d;
      busy       <= busy_d;
      mem_wen    <= mem_wen_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      note_count <= note_count_d;
      load_done  <= load_done_d;
      load_err   <= load_err_d;
    end
  end

  // Frame parser: next-state and registered-output values.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    hi_d         = hi_q;
    csum_d       = csum_q;
    mem_wen_d    = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    note_count_d = note_count;
    load_done_d  = 1'b0;
    load_err_d   = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == HDR_BYTE) state_d = StLen;
        end
        StLen: begin
          len_d   = rx_data;
          csum_d  = rx_data;
          idx_d   = '0;
          state_d = (rx_data == 8'd0) ? StCsum : StHi;
        end
        StHi: begin
          hi_d    = rx_data[3:0];
          csum_d  = csum_q ^ rx_data;
          state_d = StLo;
        end
        StLo: begin
          csum_d      = csum_q ^ rx_data;
          mem_wen_d   = 1'b1;
          mem_addr_d  = ADDR_W'(idx_q);
          mem_wdata_d = {hi_q, rx_data};
          idx_d       = idx_q + 8'd1;
          state_d     = ((idx_q + 8'd1) == len_q) ? StCsum : StHi;
        end
        StCsum: begin
          if (rx_data == csum_q) begin
            note_count_d = len_q;
            load_done_d  = 1'b1;
          end else begin
            note_count_d = 8'd0;
            load_err_d   = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Stalled frame abort; only reachable when no byte arrives this cycle.
    if (tmo_hit) begin
      state_d      = StIdle;
      note_count_d = 8'd0;
      load_err_d   = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

endmodule
